// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the DIM x DIM matrix-multiply datapath: walks (i,j,k), drives
// operand reads, accumulator strobes, final-data load, result write and overflow tally.
module matmul_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 4,
  localparam int AW        = $clog2(DIM*DIM),
  localparam int CW        = $clog2(DIM*DIM+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          fd_invalid,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic          rd_en,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          fd_en,
  output logic [AW-1:0] c_addr,
  output logic          c_we,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic [CW-1:0] ovf_count
);

  localparam int IW = $clog2(DIM);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIM-1);
  localparam logic [CW-1:0] OVF_MAX  = CW'(DIM*DIM);

  generate
    if (DATA_WIDTH < 1 || DIM < 2) begin : g_param_check
      $error("matmul_seq_ctrl: DATA_WIDTH must be >= 1 and DIM >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_LOAD, S_STORE, S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] i_reg, i_next, j_reg, j_next, k_reg, k_next;
  logic          ovf_clr, ovf_hit;

  function automatic logic [AW-1:0] lin(input logic [IW-1:0] row, input logic [IW-1:0] col);
    return AW'(row) * AW'(DIM) + AW'(col);
  endfunction

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    ovf_clr    = 1'b0;
    ovf_hit    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!abort && start) begin
          state_next = S_ISSUE;
          i_next     = '0;
          j_next     = '0;
          k_next     = '0;
          ovf_clr    = 1'b1;
        end
      end
      S_ISSUE: begin
        if (k_reg == LAST_IDX) begin
          state_next = S_WAIT;
          k_next     = '0;
        end else begin
          k_next = k_reg + IW'(1);
        end
      end
      S_WAIT:  state_next = S_LOAD;
      S_LOAD:  state_next = S_STORE;
      S_STORE: begin
        // The write is already on the bus this cycle, so its flag counts even if aborted.
        ovf_hit = fd_invalid;
        if (j_reg == LAST_IDX) begin
          j_next = '0;
          if (i_reg == LAST_IDX) begin
            i_next     = '0;
            state_next = S_DONE;
          end else begin
            i_next     = i_reg + IW'(1);
            state_next = S_ISSUE;
          end
        end else begin
          j_next     = j_reg + IW'(1);
          state_next = S_ISSUE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort && state_reg != S_IDLE) state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_addr    <= '0;
      b_addr    <= '0;
      c_addr    <= '0;
      rd_en     <= 1'b0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      fd_en     <= 1'b0;
      c_we      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      ovf_count <= '0;
    end else begin
      rd_en   <= (state_next == S_ISSUE);
      acc_clr <= (state_next == S_ISSUE) && (k_next == '0);
      acc_en  <= rd_en && (state_next != S_IDLE);
      fd_en   <= (state_next == S_LOAD);
      c_we    <= (state_next == S_STORE);
      done    <= (state_next == S_DONE);
      busy    <= (state_next != S_IDLE);
      if (state_next == S_ISSUE) begin
        a_addr <= lin(i_next, k_next);
        b_addr <= lin(k_next, j_next);
      end
      if (state_next == S_STORE) c_addr <= lin(i_reg, j_reg);
      if (ovf_clr) begin
        overflow  <= 1'b0;
        ovf_count <= '0;
      end else if (ovf_hit) begin
        overflow <= 1'b1;
        if (ovf_count != OVF_MAX) ovf_count <= ovf_count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Randomised bench for matmul_seq_ctrl: a cycle-indexed run model predicts every
// output each cycle, with literal expectations pinning the key timing points.
module tb_matmul_seq_ctrl;

  localparam int DIM  = 4;
  localparam int DW   = 8;
  localparam int AW   = $clog2(DIM*DIM);
  localparam int CW   = $clog2(DIM*DIM+1);
  localparam int LAST = DIM*DIM*(DIM+3);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          fd_invalid = 1'b0;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic          rd_en, acc_clr, acc_en, fd_en, c_we, busy, done, overflow;
  logic [CW-1:0] ovf_count;

  matmul_seq_ctrl #(.DATA_WIDTH(DW), .DIM(DIM)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .fd_invalid(fd_invalid),
    .a_addr(a_addr), .b_addr(b_addr), .rd_en(rd_en), .acc_clr(acc_clr), .acc_en(acc_en),
    .fd_en(fd_en), .c_addr(c_addr), .c_we(c_we), .busy(busy), .done(done),
    .overflow(overflow), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int we_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Run model: m_n is the 1-based cycle number within the current run.
  bit m_active, m_ovf;
  int m_n, m_a, m_b, m_c, m_cnt;

  always @(posedge clk or posedge reset) begin
    int e, p;
    if (reset) begin
      m_active = 0; m_n = 0; m_a = 0; m_b = 0; m_c = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      if (!m_active) begin
        if (start && !abort) begin
          m_active = 1; m_n = 1; m_ovf = 0; m_cnt = 0;
        end
      end else begin
        if (m_n <= LAST && (m_n-1) % (DIM+3) == DIM+2 && fd_invalid === 1'b1) begin
          m_ovf = 1;
          if (m_cnt < DIM*DIM) m_cnt++;
        end
        if (abort || m_n == LAST+1) begin
          m_active = 0; m_n = 0;
        end else begin
          m_n++;
        end
      end
      if (m_active && m_n <= LAST) begin
        e = (m_n-1) / (DIM+3);
        p = (m_n-1) % (DIM+3);
        if (p < DIM) begin
          m_a = (e / DIM) * DIM + p;
          m_b = p * DIM + (e % DIM);
        end
        if (p == DIM+2) m_c = e;
      end
    end
  end

  always @(negedge clk) begin
    int p;
    p = (m_active && m_n <= LAST) ? (m_n-1) % (DIM+3) : -1;
    chk("rd_en",     rd_en,     p >= 0 && p < DIM);
    chk("acc_clr",   acc_clr,   p == 0);
    chk("acc_en",    acc_en,    p >= 1 && p <= DIM);
    chk("fd_en",     fd_en,     p == DIM+1);
    chk("c_we",      c_we,      p == DIM+2);
    chk("done",      done,      m_active && m_n == LAST+1);
    chk("busy",      busy,      m_active);
    chk("a_addr",    a_addr,    m_a);
    chk("b_addr",    b_addr,    m_b);
    chk("c_addr",    c_addr,    m_c);
    chk("overflow",  overflow,  m_ovf);
    chk("ovf_count", ovf_count, m_cnt);
    if (c_we === 1'b1) we_count++;
  end

  // mode 1 = directed run with fixed flags and literal checkpoints, else random flags.
  task automatic run(input int mode, input int abort_at, input int reset_at, input bit noise,
                     output int done_cyc);
    int ae, e, p;
    ae = 0; done_cyc = 0; we_count = 0;
    start = 1'b1; abort = 1'b0; fd_invalid = 1'b0;
    for (int cyc = 1; cyc <= 130; cyc++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; fd_invalid = 1'b0;
      if (done === 1'b1 && done_cyc == 0) done_cyc = cyc;
      if (cyc == 1) begin
        chk("c1_a_addr", a_addr, 0);
        chk("c1_b_addr", b_addr, 0);
        chk("c1_acc_clr", acc_clr, 1);
        chk("c1_busy", busy, 1);
        chk("c1_overflow_cleared", overflow, 0);
        chk("c1_ovf_count_cleared", ovf_count, 0);
      end
      if (done_cyc != 0 && cyc == done_cyc + 1) begin
        chk("busy_after_done", busy, 0);
        break;
      end
      if (abort_at != 0 && cyc == abort_at + 1) begin
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_acc_en", acc_en, 0);
        chk("abort_c_we", c_we, 0);
      end
      if (abort_at != 0 && cyc == abort_at + 4) break;
      if (mode == 1) begin
        if (cyc <= 4) chk("b_addr_seq", b_addr, 4*(cyc-1));
        if (cyc == 5) chk("fd_en_c5", fd_en, 0);
        if (cyc == 6) chk("fd_en_c6", fd_en, 1);
        if (cyc == 7) begin
          chk("c_we_c7", c_we, 1);
          chk("c_addr_c7", c_addr, 0);
        end
        if (cyc >= 78 && cyc <= 81) begin
          chk("e23_a_addr", a_addr, 8 + (cyc-78));
          chk("e23_b_addr", b_addr, 3 + 4*(cyc-78));
        end
        if (cyc >= 78 && cyc <= 84 && acc_en === 1'b1) ae++;
        if (cyc == 84) begin
          chk("e23_c_we", c_we, 1);
          chk("e23_c_addr", c_addr, 11);
        end
        if (done === 1'b1) begin
          chk("done_overflow", overflow, 1);
          chk("done_ovf_count", ovf_count, 2);
        end
        if (cyc == 50) start = 1'b1;
      end
      if (m_active && m_n <= LAST) begin
        e = (m_n-1) / (DIM+3);
        p = (m_n-1) % (DIM+3);
        if (mode == 1) fd_invalid = (p == DIM+2) && (e == 5 || e == 9);
        else           fd_invalid = 1'($urandom_range(0, 1));
      end
      if (noise && cyc >= 2 && cyc <= 110 && (abort_at == 0 || cyc < abort_at) &&
          $urandom_range(0, 7) == 0) start = 1'b1;
      if (cyc == abort_at) abort = 1'b1;
      if (cyc == reset_at) begin
        #1 reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_acc_en", acc_en, 0);
        chk("rst_a_addr", a_addr, 0);
        chk("rst_b_addr", b_addr, 0);
        chk("rst_ovf_count", ovf_count, 0);
        #1 reset = 1'b0;
        break;
      end
    end
    start = 1'b0; abort = 1'b0; fd_invalid = 1'b0;
    if (mode == 1) chk("e23_acc_en_count", ae, 4);
    $display("run mode=%0d abort_at=%0d reset_at=%0d done_cycle=%0d c_we=%0d ovf=%0b count=%0d",
             mode, abort_at, reset_at, done_cyc, we_count, overflow, ovf_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    run(1, 0, 0, 1'b0, dc);
    chk("directed_done_cycle", dc, 113);
    chk("directed_c_we_pulses", we_count, 16);

    run(2, 0, 0, 1'b1, dc);
    chk("random_done_cycle", dc, 113);
    chk("random_c_we_pulses", we_count, 16);

    run(2, 30, 0, 1'b0, dc);
    chk("abort_no_done", dc, 0);

    run(2, 0, 40, 1'b0, dc);
    chk("reset_no_done", dc, 0);

    run(2, 0, 0, 1'b0, dc);
    chk("post_reset_done_cycle", dc, 113);

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_rd_en", rd_en, 0);
    @(negedge clk);
    chk("start_abort_idle", busy, 0);

    for (int r = 0; r < 4; r++) begin
      run(2, $urandom_range(1, LAST), 0, 1'b1, dc);
      chk("rand_abort_no_done", dc, 0);
    end

    run(2, 0, 0, 1'b1, dc);
    chk("final_done_cycle", dc, 113);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
